// File: rtl/sum_accum.sv
// Burst accumulator: sums a length-prefixed burst of adder results and
// presents the registered total plus a sticky overflow flag on a valid/ready port.
module sum_accum #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ACC_W  = 40,
    parameter int unsigned LEN_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf,
    output logic              busy
);

    localparam int unsigned SUM_W = ACC_W + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_nxt;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] cnt_nxt;
    logic             ovf;
    logic             ovf_nxt;
    logic [SUM_W-1:0] add_c;
    logic             beat_c;
    logic             enter_done_c;

    // in_ready is a register that mirrors state==ACCUM, so it gates the beat directly
    assign beat_c       = in_valid && in_ready;
    assign add_c        = SUM_W'(acc) + SUM_W'(in_data);
    assign enter_done_c = (state_nxt == DONE) && (state != DONE);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            ovf   <= ovf_nxt;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        ovf_nxt   = ovf;
        case (state)
            IDLE: begin
                if (start) begin
                    acc_nxt = '0;
                    ovf_nxt = 1'b0;
                    cnt_nxt = len;
                    if (len == '0) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (beat_c) begin
                    acc_nxt = add_c[ACC_W-1:0];
                    ovf_nxt = ovf | add_c[ACC_W];
                    cnt_nxt = cnt - LEN_W'(1);
                    if (cnt == LEN_W'(1)) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Registered outputs; the result is captured once on entry to DONE and held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
        end else begin
            in_ready  <= (state_nxt == ACCUM);
            out_valid <= (state_nxt == DONE);
            busy      <= (state_nxt != IDLE);
            if (enter_done_c) begin
                out_sum <= acc_nxt;
                out_ovf <= ovf_nxt;
            end
        end
    end

endmodule

// File: tb/tb_sum_accum.sv
// Self-checking bench for sum_accum: table-driven bursts, hand-written corner
// sequences, and a scoreboard compared at the result handshake.
module tb_sum_accum;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ACC_W  = 32;
    localparam int unsigned LEN_W  = 5;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic              out_ovf;
    logic              busy;

    int checks = 0;
    int errors = 0;

    logic [ACC_W-1:0] sb_sum[$];
    logic             sb_ovf[$];

    sum_accum #(.DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_ovf(out_ovf), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Independent reference: 33-bit adds, sticky carry
    function automatic logic [32:0] model(input logic [31:0] b[$]);
        logic [31:0] a;
        logic [32:0] t;
        logic        o;
        a = '0;
        o = 1'b0;
        foreach (b[i]) begin
            t = {1'b0, a} + {1'b0, b[i]};
            o = o | t[32];
            a = t[31:0];
        end
        return {o, a};
    endfunction

    // Result monitor: scoreboard pop on handshake, stability while stalled
    logic             stalled = 1'b0;
    logic [ACC_W-1:0] held_sum;
    logic             held_ovf;
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else if (out_valid && out_ready) begin
            if (sb_sum.size() == 0) begin
                chk("unexpected_result", 64'(out_valid), 64'(0));
            end else begin
                chk("out_sum", 64'(out_sum), 64'(sb_sum.pop_front()));
                chk("out_ovf", 64'(out_ovf), 64'(sb_ovf.pop_front()));
            end
            stalled = 1'b0;
        end else if (out_valid) begin
            if (stalled) begin
                chk("sum_stable", 64'(out_sum), 64'(held_sum));
                chk("ovf_stable", 64'(out_ovf), 64'(held_ovf));
            end
            held_sum = out_sum;
            held_ovf = out_ovf;
            stalled  = 1'b1;
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_burst(input int n, input logic [31:0] b[$], input bit gaps,
                            input int hold, input bit mid_start, input bit hs_start,
                            input logic [31:0] esum, input bit eovf);
        int tries;
        sb_sum.push_back(esum);
        sb_ovf.push_back(eovf);
        start = 1'b1;
        len   = LEN_W'(n);
        tick();
        start = 1'b0;
        len   = LEN_W'($urandom);
        chk("busy_after_start", 64'(busy), 64'(1));
        chk("in_ready_after_start", 64'(in_ready), 64'(n != 0));
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat (i % 4) begin
                    in_data = $urandom;
                    tick();
                end
            end
            if (mid_start && i == 2) begin
                start = 1'b1;
                len   = LEN_W'(2);
            end
            in_valid = 1'b1;
            in_data  = b[i];
            tries = 0;
            while (!in_ready && tries < 50) begin
                tick();
                tries++;
            end
            if (tries >= 50) chk("in_ready_timeout", 64'(in_ready), 64'(1));
            tick();
            start    = 1'b0;
            in_valid = 1'b0;
            in_data  = $urandom;
        end
        chk("out_valid_latency", 64'(out_valid), 64'(1));
        chk("in_ready_in_done", 64'(in_ready), 64'(0));
        repeat (hold) tick();
        chk("out_valid_held", 64'(out_valid), 64'(1));
        out_ready = 1'b1;
        if (hs_start) begin
            start = 1'b1;
            len   = LEN_W'(3);
        end
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        chk("out_valid_after_hs", 64'(out_valid), 64'(0));
        chk("busy_after_hs", 64'(busy), 64'(0));
        tick();
        chk("idle_stays", 64'(busy), 64'(0));
    endtask

    typedef struct {
        int               n;
        logic [31:0]      beats[5];
        bit               gaps;
        int               hold;
        logic [31:0]      esum;
        bit               eovf;
    } vec_t;

    function automatic vec_t mk(int n, logic [31:0] b0, logic [31:0] b1, logic [31:0] b2,
                                logic [31:0] b3, logic [31:0] b4, bit gaps, int hold,
                                logic [31:0] esum, bit eovf);
        vec_t v;
        v.n = n;
        v.beats[0] = b0; v.beats[1] = b1; v.beats[2] = b2; v.beats[3] = b3; v.beats[4] = b4;
        v.gaps = gaps; v.hold = hold; v.esum = esum; v.eovf = eovf;
        return v;
    endfunction

    vec_t        tbl[7];
    logic [31:0] q[$];
    logic [32:0] m;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = mk(3, 1, 2, 3, 0, 0, 0, 0, 32'd6, 0);
        tbl[1] = mk(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 32'hFFFF_FFFE, 1);
        tbl[2] = mk(1, 5, 0, 0, 0, 0, 0, 0, 32'd5, 0);
        tbl[3] = mk(4, 10, 10, 10, 10, 0, 1, 5, 32'd40, 0);
        tbl[4] = mk(0, 0, 0, 0, 0, 0, 0, 2, 32'd0, 0);
        tbl[5] = mk(3, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 0, 0, 1, 1, 32'h8000_0000, 1);
        tbl[6] = mk(5, 100, 200, 300, 400, 500, 0, 3, 32'd1500, 0);

        rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_sum", 64'(out_sum), 64'(0));
        chk("rst_out_ovf", 64'(out_ovf), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (tbl[k]) begin
            q = {};
            for (int j = 0; j < tbl[k].n; j++) q.push_back(tbl[k].beats[j]);
            do_burst(tbl[k].n, q, tbl[k].gaps, tbl[k].hold, 0, 0, tbl[k].esum, tbl[k].eovf);
        end

        // Start pulsed mid-burst must not restart or resize it
        q = {};
        for (int j = 0; j < 9; j++) q.push_back($urandom);
        m = model(q);
        do_burst(9, q, 0, 0, 1, 0, m[31:0], m[32]);

        // Start coincident with the result handshake is dropped
        q = {};
        q.push_back(32'd11);
        q.push_back(32'd22);
        do_burst(2, q, 0, 1, 0, 1, 32'd33, 0);

        // Maximum-length burst
        q = {};
        for (int j = 0; j < 31; j++) q.push_back($urandom);
        m = model(q);
        do_burst(31, q, 1, 0, 0, 0, m[31:0], m[32]);

        // Reset in the middle of a burst abandons it
        start = 1'b1;
        len   = LEN_W'(4);
        tick();
        start = 1'b0;
        for (int j = 0; j < 2; j++) begin
            in_valid = 1'b1;
            in_data  = 32'd9;
            tick();
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_in_ready", 64'(in_ready), 64'(0));
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_out_sum", 64'(out_sum), 64'(0));
        chk("midrst_out_ovf", 64'(out_ovf), 64'(0));
        tick();
        tick();
        rst_n = 1'b1;
        chk("postrst_out_valid", 64'(out_valid), 64'(0));
        q = {};
        q.push_back(32'd7);
        do_burst(1, q, 0, 0, 0, 0, 32'd7, 0);

        // A stretch of idle with upstream valid must accept nothing
        in_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            in_data = $urandom;
            tick();
            chk("idle_in_ready", 64'(in_ready), 64'(0));
            chk("idle_out_valid", 64'(out_valid), 64'(0));
        end
        in_valid = 1'b0;

        tick();
        chk("scoreboard_empty", 64'(sb_sum.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
